// File: rtl/musa_io_pkg.sv
// musa_io_pkg: register offsets and debounce state encoding for the musa I/O window
package musa_io_pkg;
  localparam logic [1:0] OFF_LED    = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_PCOUNT = 2'd2;
  typedef enum logic {DB_IDLE, DB_COUNT} db_state_t;
endpackage

// File: rtl/musa_debounce.sv
// musa_debounce: 2-flop synchronizer, stability-count debouncer and rising-edge pulse
module musa_debounce import musa_io_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  db_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic r_s1, r_s2, r_level, r_rise;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= DB_IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_s1   <= din;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      if (r_state == DB_IDLE) begin
        if (r_s2 != r_level) begin
          r_state <= DB_COUNT;
          r_cnt   <= CW'(1);
        end
      end else if (r_s2 == r_level) begin
        r_state <= DB_IDLE;
        r_cnt   <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // qualified change; pulse only on the low-to-high transition
        r_level <= r_s2;
        r_rise  <= r_s2;
        r_state <= DB_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
  assign level = r_level;
  assign rise  = r_rise;
endmodule

// File: rtl/musa_io_port.sv
// musa_io_port: memory-mapped LED/button window with registered read-back to the datapath
module musa_io_port import musa_io_pkg::*; #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int IO_BASE         = 'h3F0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_write,
  input  logic                  mem_read,
  output logic                  io_hit,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  btn_in,
  output logic [3:0]            led_out
);
  logic [ADDR_WIDTH-1:0] w_off;
  logic [1:0]            w_idx;
  logic                  w_wr, w_level, w_rise, w_unused;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [3:0]            r_led;
  logic                  r_event;
  logic [7:0]            r_pcount;
  // addresses below the base wrap to large offsets and miss the window
  assign w_off    = mem_addr - ADDR_WIDTH'(IO_BASE);
  assign io_hit   = w_off < ADDR_WIDTH'(4);
  assign w_idx    = w_off[1:0];
  assign w_wr     = mem_write & io_hit;
  assign w_unused = ^mem_wdata[DATA_WIDTH-1:4];
  musa_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_in),
    .level(w_level),
    .rise (w_rise)
  );
  always_comb begin
    w_rdata = (w_idx == OFF_LED)    ? DATA_WIDTH'(r_led) :
              (w_idx == OFF_STATUS) ? DATA_WIDTH'({r_event, w_level}) :
              (w_idx == OFF_PCOUNT) ? DATA_WIDTH'(r_pcount) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led    <= '0;
      r_event  <= 1'b0;
      r_pcount <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      r_led    <= (w_wr && w_idx == OFF_LED) ? mem_wdata[3:0] : r_led;
      r_event  <= w_rise | (r_event & ~(w_wr && w_idx == OFF_STATUS && mem_wdata[1]));
      r_pcount <= ((w_wr && w_idx == OFF_PCOUNT) ? 8'd0 : r_pcount) + 8'(w_rise);
      rd_data  <= (mem_read && io_hit) ? w_rdata : '0;
      rd_valid <= mem_read & io_hit;
    end
  end
  assign led_out = r_led;
endmodule

// File: tb/tb_musa_io_port.sv
// tb_musa_io_port: directed register, debounce, collision and reset checks for musa_io_port
module tb_musa_io_port;
  localparam logic [9:0] BASE = 10'h3F0;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic        io_hit, rd_valid, btn_in = 1'b0;
  logic [31:0] rd_data;
  logic [3:0]  led_out;
  int n_chk = 0;
  int n_fail = 0;

  musa_io_port dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .io_hit(io_hit),
    .rd_data(rd_data), .rd_valid(rd_valid), .btn_in(btn_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [9:0] a, input logic [31:0] d);
    mem_addr = a; mem_wdata = d; mem_write = 1'b1;
    step();
    mem_write = 1'b0;
  endtask

  task automatic load(input string tag, input logic [9:0] a, input logic [31:0] exp_d, input logic exp_v);
    mem_addr = a; mem_read = 1'b1;
    step();
    mem_read = 1'b0;
    chk({tag, "_data"}, rd_data, exp_d);
    chk({tag, "_valid"}, {31'd0, rd_valid}, {31'd0, exp_v});
  endtask

  task automatic press();
    btn_in = 1'b1;
    step(20);
    btn_in = 1'b0;
    step(20);
  endtask

  initial begin
    step(2);
    chk("rst_led", {28'd0, led_out}, 32'd0);
    chk("rst_rdata", rd_data, 32'd0);
    chk("rst_rvalid", {31'd0, rd_valid}, 32'd0);
    rst = 1'b0;
    mem_addr = 10'h000; #1;
    chk("hit_zero", {31'd0, io_hit}, 32'd0);
    mem_addr = BASE; #1;
    chk("hit_base", {31'd0, io_hit}, 32'd1);
    // LED store and load
    store(BASE, 32'hA5);
    chk("led_store", {28'd0, led_out}, 32'h5);
    load("led_load", BASE, 32'h5, 1'b1);
    step();
    chk("rvalid_drop", {31'd0, rd_valid}, 32'd0);
    chk("rdata_drop", rd_data, 32'd0);
    load("pcount_init", BASE + 10'd2, 32'd0, 1'b1);
    // clean press: level after 18 edges, event one edge later
    btn_in = 1'b1;
    step(17);
    load("stat_e17", BASE + 10'd1, 32'd0, 1'b1);
    load("stat_e18", BASE + 10'd1, 32'd1, 1'b1);
    load("stat_e19", BASE + 10'd1, 32'd3, 1'b1);
    load("pcount_1", BASE + 10'd2, 32'd1, 1'b1);
    step(15);
    load("stat_read_keeps", BASE + 10'd1, 32'd3, 1'b1);
    store(BASE + 10'd1, 32'd2);
    load("stat_w1c", BASE + 10'd1, 32'd1, 1'b1);
    btn_in = 1'b0;
    step(20);
    load("stat_release", BASE + 10'd1, 32'd0, 1'b1);
    load("pcount_hold", BASE + 10'd2, 32'd1, 1'b1);
    // glitch shorter than the debounce window
    store(BASE + 10'd2, 32'hFF);
    load("pcount_clr", BASE + 10'd2, 32'd0, 1'b1);
    btn_in = 1'b1;
    step(10);
    btn_in = 1'b0;
    step(25);
    load("glitch_stat", BASE + 10'd1, 32'd0, 1'b1);
    load("glitch_pcount", BASE + 10'd2, 32'd0, 1'b1);
    // 256 presses wrap the counter
    for (int i = 0; i < 256; i++) press();
    load("wrap_pcount", BASE + 10'd2, 32'd0, 1'b1);
    load("wrap_stat", BASE + 10'd1, 32'd2, 1'b1);
    store(BASE + 10'd1, 32'd2);
    load("wrap_w1c", BASE + 10'd1, 32'd0, 1'b1);
    // PCOUNT write on the press cycle: clear then increment
    btn_in = 1'b1;
    step(18);
    store(BASE + 10'd2, 32'd0);
    load("coll_pcount", BASE + 10'd2, 32'd1, 1'b1);
    store(BASE + 10'd1, 32'd2);
    load("pre_w1c_coll", BASE + 10'd1, 32'd1, 1'b1);
    btn_in = 1'b0;
    step(20);
    // W1C on the press cycle: set wins
    btn_in = 1'b1;
    step(18);
    store(BASE + 10'd1, 32'd2);
    load("coll_event", BASE + 10'd1, 32'd3, 1'b1);
    load("coll_pcount2", BASE + 10'd2, 32'd2, 1'b1);
    btn_in = 1'b0;
    step(20);
    // out-of-window accesses
    mem_addr = BASE + 10'd4; #1;
    chk("hit_above", {31'd0, io_hit}, 32'd0);
    mem_addr = BASE - 10'd1; #1;
    chk("hit_below", {31'd0, io_hit}, 32'd0);
    mem_addr = BASE + 10'd3; #1;
    chk("hit_top", {31'd0, io_hit}, 32'd1);
    store(BASE + 10'd4, 32'hF);
    store(BASE - 10'd1, 32'hF);
    chk("oow_led", {28'd0, led_out}, 32'h5);
    load("oow_above", BASE + 10'd4, 32'd0, 1'b0);
    load("oow_below", BASE - 10'd1, 32'd0, 1'b0);
    store(BASE + 10'd3, 32'hF);
    load("reserved", BASE + 10'd3, 32'd0, 1'b1);
    // simultaneous load and store returns the pre-store value
    mem_addr = BASE; mem_wdata = 32'hA; mem_write = 1'b1; mem_read = 1'b1;
    step();
    mem_write = 1'b0; mem_read = 1'b0;
    chk("rw_old", rd_data, 32'h5);
    chk("rw_led", {28'd0, led_out}, 32'hA);
    // reset mid-count with button held
    btn_in = 1'b1;
    step(10);
    rst = 1'b1; mem_addr = BASE; mem_read = 1'b1;
    step();
    mem_read = 1'b0;
    chk("mid_rst_led", {28'd0, led_out}, 32'd0);
    chk("mid_rst_rvalid", {31'd0, rd_valid}, 32'd0);
    chk("mid_rst_rdata", rd_data, 32'd0);
    rst = 1'b0;
    step(17);
    load("requal_e17", BASE + 10'd1, 32'd0, 1'b1);
    load("requal_e18", BASE + 10'd1, 32'd1, 1'b1);
    load("requal_pcount", BASE + 10'd2, 32'd1, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
